// File: rtl/stlb_way_unit.sv
// One way of the second-level TLB: NSET entries of {valid, tag, pcid, ppn}.
// Lookup is combinational. One write port installs an entry. Shutdown
// clears the whole way in one cycle. The parent stlb owns PLRU and victim choice.
module stlb_way_unit #(
  parameter int unsigned SADDR = 64,
  parameter int unsigned SPAGE = 12,
  parameter int unsigned NSET  = 8,
  parameter int unsigned SPCID = 12,
  localparam int unsigned PPNW = SADDR - SPAGE,
  localparam int unsigned SETW = $clog2(NSET),
  localparam int unsigned TAGW = SADDR - SPAGE - SETW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            shutdown,
  input  logic [SETW-1:0]  rd_set,
  input  logic [TAGW-1:0]  rd_tag,
  input  logic [SPCID-1:0] rd_pcid,
  output logic             hit,
  output logic [PPNW-1:0]  rd_ppn,
  input  logic             we,
  input  logic [SETW-1:0]  wr_set,
  input  logic [TAGW-1:0]  wr_tag,
  input  logic [SPCID-1:0] wr_pcid,
  input  logic [PPNW-1:0]  wr_ppn,
  output logic [NSET-1:0]  valid
);

  logic [NSET-1:0]  r_valid;
  logic [TAGW-1:0]  r_tag  [NSET];
  logic [SPCID-1:0] r_pcid [NSET];
  logic [PPNW-1:0]  r_ppn  [NSET];

  logic             w_hit;

  // Entry storage: async clear, shutdown flush beats a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < NSET; i++) begin
        r_tag[i]  <= '0;
        r_pcid[i] <= '0;
        r_ppn[i]  <= '0;
      end
    end else if (shutdown) begin
      r_valid <= '0;
      for (int i = 0; i < NSET; i++) begin
        r_tag[i]  <= '0;
        r_pcid[i] <= '0;
        r_ppn[i]  <= '0;
      end
    end else if (we) begin
      r_valid[wr_set] <= 1'b1;
      r_tag[wr_set]   <= wr_tag;
      r_pcid[wr_set]  <= wr_pcid;
      r_ppn[wr_set]   <= wr_ppn;
    end
  end

  // Combinational lookup; the valid bit gates the match so zero tags are ordinary.
  always_comb begin
    w_hit  = r_valid[rd_set] && (r_tag[rd_set] == rd_tag) && (r_pcid[rd_set] == rd_pcid);
    rd_ppn = w_hit ? r_ppn[rd_set] : '0;
  end

  assign hit   = w_hit;
  assign valid = r_valid;

endmodule

// File: tb/tb_stlb_way_unit.sv
// Directed self-checking bench for stlb_way_unit.
module tb_stlb_way_unit;

  localparam int unsigned SETW  = 3;
  localparam int unsigned TAGW  = 49;
  localparam int unsigned SPCID = 12;
  localparam int unsigned PPNW  = 52;

  logic             clk;
  logic             rst_n;
  logic             shutdown;
  logic [SETW-1:0]  rd_set;
  logic [TAGW-1:0]  rd_tag;
  logic [SPCID-1:0] rd_pcid;
  logic             hit;
  logic [PPNW-1:0]  rd_ppn;
  logic             we;
  logic [SETW-1:0]  wr_set;
  logic [TAGW-1:0]  wr_tag;
  logic [SPCID-1:0] wr_pcid;
  logic [PPNW-1:0]  wr_ppn;
  logic [7:0]       valid;

  int n_pass;
  int n_total;

  stlb_way_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .shutdown (shutdown),
    .rd_set   (rd_set),
    .rd_tag   (rd_tag),
    .rd_pcid  (rd_pcid),
    .hit      (hit),
    .rd_ppn   (rd_ppn),
    .we       (we),
    .wr_set   (wr_set),
    .wr_tag   (wr_tag),
    .wr_pcid  (wr_pcid),
    .wr_ppn   (wr_ppn),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a lookup and let the combinational path settle.
  task automatic look(input int s, input logic [TAGW-1:0] t, input logic [SPCID-1:0] p);
    rd_set  = SETW'(s);
    rd_tag  = t;
    rd_pcid = p;
    #1;
  endtask

  // One write cycle; returns 1 time unit after the edge.
  task automatic write(input int s, input logic [TAGW-1:0] t, input logic [SPCID-1:0] p,
                       input logic [PPNW-1:0] n);
    we      = 1'b1;
    wr_set  = SETW'(s);
    wr_tag  = t;
    wr_pcid = p;
    wr_ppn  = n;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic pulse_shutdown();
    shutdown = 1'b1;
    @(posedge clk);
    #1;
    shutdown = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 8; i++) write(i, TAGW'(49'h100 + i), SPCID'(i), PPNW'(52'h1000 + i));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      look(i, '0, '0);
      n_total++;
      if (hit !== 1'b0 || rd_ppn !== '0) $display("FAIL reset_lookup set=%0d hit=%b ppn=%h want 0/0", i, hit, rd_ppn);
      else n_pass++;
    end
    n_total++;
    if (valid !== 8'h00) $display("FAIL reset_valid got=%h want=00", valid);
    else n_pass++;
  endtask

  task automatic test_write_lookup();
    write(3, 49'h1234, 12'd5, 52'hABCDE);
    look(3, 49'h1234, 12'd5);
    n_total++;
    if (hit !== 1'b1 || rd_ppn !== 52'hABCDE)
      $display("FAIL wr_hit hit=%b ppn=%h want 1/abcde", hit, rd_ppn);
    else n_pass++;
    n_total++;
    if (valid !== 8'h08) $display("FAIL wr_valid got=%h want=08", valid);
    else n_pass++;
    look(3, 49'h1234, 12'd6);
    n_total++;
    if (hit !== 1'b0 || rd_ppn !== '0) $display("FAIL pcid_miss hit=%b ppn=%h want 0/0", hit, rd_ppn);
    else n_pass++;
    look(3, 49'h1235, 12'd5);
    n_total++;
    if (hit !== 1'b0) $display("FAIL tag_miss hit=%b want 0", hit);
    else n_pass++;
    look(2, 49'h1234, 12'd5);
    n_total++;
    if (hit !== 1'b0) $display("FAIL set_miss hit=%b want 0", hit);
    else n_pass++;
  endtask

  task automatic test_no_bypass();
    pulse_shutdown();
    look(3, 49'h1234, 12'd5);
    we      = 1'b1;
    wr_set  = 3'd3;
    wr_tag  = 49'h1234;
    wr_pcid = 12'd5;
    wr_ppn  = 52'h777;
    #1;
    n_total++;
    if (hit !== 1'b0) $display("FAIL no_bypass hit=%b want 0", hit);
    else n_pass++;
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    n_total++;
    if (hit !== 1'b1 || rd_ppn !== 52'h777)
      $display("FAIL after_write hit=%b ppn=%h want 1/777", hit, rd_ppn);
    else n_pass++;
  endtask

  task automatic test_overwrite();
    write(3, 49'h55, 12'd5, 52'h1);
    look(3, 49'h1234, 12'd5);
    n_total++;
    if (hit !== 1'b0) $display("FAIL old_tag hit=%b want 0", hit);
    else n_pass++;
    look(3, 49'h55, 12'd5);
    n_total++;
    if (hit !== 1'b1 || rd_ppn !== 52'h1) $display("FAIL new_tag hit=%b ppn=%h want 1/1", hit, rd_ppn);
    else n_pass++;
  endtask

  task automatic test_shutdown();
    fill_all();
    n_total++;
    if (valid !== 8'hFF) $display("FAIL fill_valid got=%h want=ff", valid);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      look(i, TAGW'(49'h100 + i), SPCID'(i));
      n_total++;
      if (hit !== 1'b1 || rd_ppn !== PPNW'(52'h1000 + i))
        $display("FAIL fill_hit set=%0d hit=%b ppn=%h want 1/%h", i, hit, rd_ppn, 52'h1000 + i);
      else n_pass++;
    end
    pulse_shutdown();
    n_total++;
    if (valid !== 8'h00) $display("FAIL sd_valid got=%h want=00", valid);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      look(i, TAGW'(49'h100 + i), SPCID'(i));
      n_total++;
      if (hit !== 1'b0 || rd_ppn !== '0) $display("FAIL sd_miss set=%0d hit=%b ppn=%h want 0/0", i, hit, rd_ppn);
      else n_pass++;
      // Cleared fields are zero but must still miss without the valid bit.
      look(i, '0, '0);
      n_total++;
      if (hit !== 1'b0) $display("FAIL sd_zero set=%0d hit=%b want 0", i, hit);
      else n_pass++;
    end
    shutdown = 1'b1;
    write(2, 49'h77, 12'd1, 52'h9);
    shutdown = 1'b0;
    look(2, 49'h77, 12'd1);
    n_total++;
    if (hit !== 1'b0 || valid !== 8'h00) $display("FAIL sd_vs_we hit=%b valid=%h want 0/00", hit, valid);
    else n_pass++;
    // Tag 0 / pcid 0 is an ordinary value once installed.
    write(0, '0, '0, 52'h42);
    look(0, '0, '0);
    n_total++;
    if (hit !== 1'b1 || rd_ppn !== 52'h42) $display("FAIL zero_entry hit=%b ppn=%h want 1/42", hit, rd_ppn);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    fill_all();
    look(5, 49'h105, 12'd5);
    n_total++;
    if (hit !== 1'b1 || valid !== 8'hFF) $display("FAIL pre_rst hit=%b valid=%h want 1/ff", hit, valid);
    else n_pass++;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (hit !== 1'b0 || rd_ppn !== '0 || valid !== 8'h00)
      $display("FAIL async_rst hit=%b ppn=%h valid=%h want 0/0/00", hit, rd_ppn, valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    shutdown = 1'b0;
    we       = 1'b0;
    wr_set   = '0;
    wr_tag   = '0;
    wr_pcid  = '0;
    wr_ppn   = '0;
    rd_set   = '0;
    rd_tag   = '0;
    rd_pcid  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_lookup();
    test_no_bypass();
    test_overwrite();
    test_shutdown();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
